// File: rtl/serial_word_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Digit counter width; a single-digit configuration still needs one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/serial_word_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full adders; also exposes the
// carry entering its top bit so the caller can derive signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_top
);
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout  = c[DIGIT];
  assign c_top = c[DIGIT-1];
endmodule

// File: rtl/serial_word_adder.sv
// Multi-cycle add/subtract processing one DIGIT-bit slice per clock, LSB first.
// done pulses NDIG edges after acceptance; start is ignored while busy.
module serial_word_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = cnt_width(NDIG);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [DIGIT-1:0] dsum;
  logic             dcout, dctop;
  logic [WIDTH-1:0] res_shift;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s     (dsum),
    .cout  (dcout),
    .c_top (dctop)
  );

  // New digit enters at the top; after NDIG shifts the word is LSB-aligned.
  assign res_shift = WIDTH'({dsum, res_q} >> DIGIT);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dcout;
        res_d   = res_shift;
        if (k_q == KW'(NDIG - 1)) begin
          k_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_shift;
          cout_d  = dcout;
          ovf_d   = dcout ^ dctop;
          state_d = IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_word_adder.sv
// Scoreboard bench for three digit widths (4, 16, 1) of a 16-bit serial adder.
module tb_serial_word_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start[3];
  logic        sub[3];
  logic [15:0] a[3];
  logic [15:0] b[3];
  logic        cin[3];
  logic        busy[3];
  logic        done[3];
  logic [15:0] sum[3];
  logic        cout[3];
  logic        ovf[3];

  exp_t exp_q[3][$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    serial_word_adder #(.WIDTH(16), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start[g]),
      .sub   (sub[g]),
      .a     (a[g]),
      .b     (b[g]),
      .cin   (cin[g]),
      .busy  (busy[g]),
      .done  (done[g]),
      .sum   (sum[g]),
      .cout  (cout[g]),
      .ovf   (ovf[g])
    );
  end

  function automatic int ndig(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: integer arithmetic on the unsigned and signed interpretations.
  task automatic model(input logic s, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, output logic [15:0] r, output logic co,
                       output logic ov);
    int ux, uy, sx, sy, ures, sres;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      ures = ux - uy;
      sres = sx - sy;
      co   = (ux >= uy);
    end else begin
      ures = ux + uy + int'(ci);
      sres = sx + sy + int'(ci);
      co   = (ures > 65535);
    end
    r  = ures[15:0];
    ov = (sres > 32767) || (sres < -32768);
  endtask

  task automatic issue(input int g, input logic s, input logic [15:0] x,
                       input logic [15:0] y, input logic ci, input logic [15:0] es,
                       input logic ec, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy[g]) begin
      chk("issue_timeout", 1, 0);
    end else begin
      start[g] = 1'b1;
      sub[g]   = s;
      a[g]     = x;
      b[g]     = y;
      cin[g]   = ci;
      exp_q[g].push_back('{es, ec, eo, cyc + 1});
      @(negedge clk);
      start[g] = 1'b0;
      a[g]     = 16'($urandom);
      b[g]     = 16'($urandom);
      cin[g]   = 1'($urandom);
      sub[g]   = 1'($urandom);
    end
  endtask

  task automatic issue_rand(input int g);
    logic [15:0] x, y, r;
    logic        s, ci, co, ov;
    x  = 16'($urandom);
    y  = 16'($urandom);
    s  = 1'($urandom_range(0, 1));
    ci = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: x = 16'h7FFF;
      1: y = 16'hFFFF;
      2: y = x;
      default: ;
    endcase
    model(s, x, y, ci, r, co, ov);
    issue(g, s, x, y, ci, r, co, ov);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (done[g] === 1'b1) begin
        if (exp_q[g].size() == 0) begin
          chk($sformatf("unexpected_done_dut%0d", g), 1, 0);
        end else begin
          exp_t e;
          e = exp_q[g].pop_front();
          chk($sformatf("sum_dut%0d", g), int'(sum[g]), int'(e.s));
          chk($sformatf("cout_dut%0d", g), int'(cout[g]), int'(e.c));
          chk($sformatf("ovf_dut%0d", g), int'(ovf[g]), int'(e.o));
          chk($sformatf("latency_dut%0d", g), cyc - e.acc, ndig(g));
          chk($sformatf("busy_at_done_dut%0d", g), int'(busy[g]), 0);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0; sub[g] = 1'b0; a[g] = '0; b[g] = '0; cin[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_busy_dut%0d", g), int'(busy[g]), 0);
      chk($sformatf("rst_done_dut%0d", g), int'(done[g]), 0);
      chk($sformatf("rst_sum_dut%0d", g), int'(sum[g]), 0);
      chk($sformatf("rst_flags_dut%0d", g), int'({cout[g], ovf[g]}), 0);
    end
    rst = 1'b0;

    // Basic add; busy must stay high for the four processing cycles.
    issue(0, 1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", int'(busy[0]), 1);
      @(negedge clk);
    end
    chk("busy_after", int'(busy[0]), 0);

    // Carry out, then signed overflow issued in the done cycle.
    issue(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue(0, 1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    issue(0, 1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0);

    // Starts while busy must be ignored.
    issue(0, 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    start[0] = 1'b1; a[0] = 16'hFFFF; b[0] = 16'hFFFF; cin[0] = 1'b1;
    @(negedge clk);
    a[0] = 16'h8000; b[0] = 16'h8000; sub[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;

    // Reset mid-operation discards it and clears outputs at once.
    issue(0, 1'b0, 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q[0].delete();
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_done", int'(done[0]), 0);
    chk("midrst_sum", int'(sum[0]), 0);
    chk("midrst_flags", int'({cout[0], ovf[0]}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(0, 1'b0, 16'hA5A5, 16'h0F0F, 1'b1, 16'hB4B5, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) issue_rand(0);
    for (int i = 0; i < 1000; i++) issue_rand(1);
    for (int i = 0; i < 1000; i++) issue_rand(2);

    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
